// File: rtl/cv32e40p_recovery_pkg.sv
// Shared types for the recovery sequencer: FSM states, shadow entry, parity helper.
// The parity bit fields exist only when CV32E40P_RECOVERY_PARITY_EN is defined.
package cv32e40p_recovery_pkg;

  localparam int unsigned DEFAULT_HALT_TIMEOUT = 64;
  localparam int unsigned PARITY_MAX_WIDTH     = 64;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    RESTORE,
    PCREC,
    DONE
  } recovery_state_e;

  typedef struct packed {
    logic [31:0] data;
`ifdef CV32E40P_RECOVERY_PARITY_EN
    logic        parity;
`endif
  } shadow_entry_t;

  // Even parity: the stored bit makes the total number of ones even.
  function automatic logic even_parity(input logic [PARITY_MAX_WIDTH-1:0] value);
    return ^value;
  endfunction

  function automatic shadow_entry_t make_pc_entry(input logic [31:0] pc);
    shadow_entry_t entry;
    entry.data = pc;
`ifdef CV32E40P_RECOVERY_PARITY_EN
    entry.parity = even_parity(PARITY_MAX_WIDTH'(pc));
`endif
    return entry;
  endfunction

endpackage

// File: rtl/cv32e40p_recovery_shadow_rf.sv
// Shadow register file: two write ports (port A wins on collision), x0 and out-of-range
// writes dropped, one even/odd register pair read per cycle. Parity with CV32E40P_RECOVERY_PARITY_EN.
module cv32e40p_recovery_shadow_rf
  import cv32e40p_recovery_pkg::*;
#(
  parameter  int unsigned NUM_REGS   = 32,
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned ADDR_WIDTH = 6,
  localparam int unsigned IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] waddr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] waddr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  input  logic [IDX_W-2:0]      rpair,
  output logic [DATA_WIDTH-1:0] rdata_even,
  output logic [DATA_WIDTH-1:0] rdata_odd,
  output logic                  rerr_even,
  output logic                  rerr_odd
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
`ifdef CV32E40P_RECOVERY_PARITY_EN
    logic                  parity;
`endif
  } entry_t;

  function automatic entry_t make_entry(input logic [DATA_WIDTH-1:0] d);
    entry_t entry;
    entry.data = d;
`ifdef CV32E40P_RECOVERY_PARITY_EN
    entry.parity = even_parity(PARITY_MAX_WIDTH'(d));
`endif
    return entry;
  endfunction

  entry_t mem [NUM_REGS];
  entry_t ent_even;
  entry_t ent_odd;
  logic   a_ok;
  logic   b_ok;

  assign a_ok = we_a && (waddr_a != '0) && (32'(waddr_a) < NUM_REGS);
  assign b_ok = we_b && (waddr_b != '0) && (32'(waddr_b) < NUM_REGS);

  // Port B is written first so a same-address port A write overrides it.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (b_ok) mem[waddr_b[IDX_W-1:0]] <= make_entry(wdata_b);
      if (a_ok) mem[waddr_a[IDX_W-1:0]] <= make_entry(wdata_a);
    end
  end

  assign ent_even   = mem[{rpair, 1'b0}];
  assign ent_odd    = mem[{rpair, 1'b1}];
  assign rdata_even = ent_even.data;
  assign rdata_odd  = ent_odd.data;

`ifdef CV32E40P_RECOVERY_PARITY_EN
  assign rerr_even = even_parity(PARITY_MAX_WIDTH'(ent_even.data)) != ent_even.parity;
  assign rerr_odd  = even_parity(PARITY_MAX_WIDTH'(ent_odd.data)) != ent_odd.parity;
`else
  assign rerr_even = 1'b0;
  assign rerr_odd  = 1'b0;
`endif

endmodule

// File: rtl/cv32e40p_recovery_sequencer.sv
// Checkpoint/restore controller: shadows RF writes and committed PC, then on request halts
// the core and replays the shadow two registers per cycle. Parity: CV32E40P_RECOVERY_PARITY_EN.
module cv32e40p_recovery_sequencer
  import cv32e40p_recovery_pkg::*;
#(
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned HALT_TIMEOUT = DEFAULT_HALT_TIMEOUT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rf_we_a_i,
  input  logic [ADDR_WIDTH-1:0] rf_waddr_a_i,
  input  logic [DATA_WIDTH-1:0] rf_wdata_a_i,
  input  logic                  rf_we_b_i,
  input  logic [ADDR_WIDTH-1:0] rf_waddr_b_i,
  input  logic [DATA_WIDTH-1:0] rf_wdata_b_i,
  input  logic                  pc_commit_i,
  input  logic [31:0]           pc_i,
  input  logic                  recover_req_i,
  input  logic                  core_halted_i,
  output logic                  core_halt_o,
  output logic                  rf_recover_o,
  output logic                  rf_we_a_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_a_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_a_o,
  output logic                  rf_we_b_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_b_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_b_o,
  output logic                  pc_recover_o,
  output logic [31:0]           recovery_pc_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int unsigned NUM_PAIRS = NUM_REGS / 2;
  localparam int unsigned PAIR_W    = $clog2(NUM_PAIRS);
  localparam int unsigned TIMER_W   = $clog2(HALT_TIMEOUT + 1);
  localparam logic [PAIR_W-1:0]  LAST_PAIR  = PAIR_W'(NUM_PAIRS - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(HALT_TIMEOUT - 1);

  recovery_state_e       state;
  logic [PAIR_W-1:0]     pair_idx;
  logic [PAIR_W-1:0]     rd_pair;
  logic [TIMER_W-1:0]    halt_timer;
  logic                  halt_lost;
  shadow_entry_t         shadow_pc;
  logic                  idle;
  logic                  last_pair;
  logic                  load_pair;
  logic                  pc_err;
  logic                  abort;
  logic [DATA_WIDTH-1:0] rd_even;
  logic [DATA_WIDTH-1:0] rd_odd;
  logic                  rd_err_even;
  logic                  rd_err_odd;

  assign idle      = (state == IDLE);
  assign last_pair = (pair_idx == LAST_PAIR);

  // Outputs are registered, so the shadow is read one pair ahead of the pair being driven.
  always_comb begin
    rd_pair = '0;
    if (state == RESTORE) rd_pair = pair_idx + 1'b1;
  end

  assign load_pair = ((state == HALT) && core_halted_i) || ((state == RESTORE) && !last_pair);

`ifdef CV32E40P_RECOVERY_PARITY_EN
  assign pc_err = even_parity(PARITY_MAX_WIDTH'(shadow_pc.data)) != shadow_pc.parity;
`else
  assign pc_err = 1'b0;
`endif

  assign abort = (load_pair && (rd_err_even || rd_err_odd)) ||
                 ((state == RESTORE) && last_pair && pc_err);

  cv32e40p_recovery_shadow_rf #(
    .NUM_REGS  (NUM_REGS),
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_shadow_rf (
    .clock     (clk_i),
    .reset     (rst_i),
    .we_a      (rf_we_a_i && idle),
    .waddr_a   (rf_waddr_a_i),
    .wdata_a   (rf_wdata_a_i),
    .we_b      (rf_we_b_i && idle),
    .waddr_b   (rf_waddr_b_i),
    .wdata_b   (rf_wdata_b_i),
    .rpair     (rd_pair),
    .rdata_even(rd_even),
    .rdata_odd (rd_odd),
    .rerr_even (rd_err_even),
    .rerr_odd  (rd_err_odd)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      pair_idx      <= '0;
      halt_timer    <= '0;
      halt_lost     <= 1'b0;
      shadow_pc     <= '0;
      core_halt_o   <= 1'b0;
      busy_o        <= 1'b0;
      rf_recover_o  <= 1'b0;
      rf_we_a_o     <= 1'b0;
      rf_waddr_a_o  <= '0;
      rf_wdata_a_o  <= '0;
      rf_we_b_o     <= 1'b0;
      rf_waddr_b_o  <= '0;
      rf_wdata_b_o  <= '0;
      pc_recover_o  <= 1'b0;
      recovery_pc_o <= '0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      rf_recover_o  <= 1'b0;
      rf_we_a_o     <= 1'b0;
      rf_waddr_a_o  <= '0;
      rf_wdata_a_o  <= '0;
      rf_we_b_o     <= 1'b0;
      rf_waddr_b_o  <= '0;
      rf_wdata_b_o  <= '0;
      pc_recover_o  <= 1'b0;
      recovery_pc_o <= '0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;

      if (abort) begin
        err_o       <= 1'b1;
        state       <= IDLE;
        busy_o      <= 1'b0;
        core_halt_o <= 1'b0;
      end else begin
        if (load_pair) begin
          rf_recover_o <= 1'b1;
          rf_we_a_o    <= (rd_pair != '0);
          rf_waddr_a_o <= ADDR_WIDTH'({rd_pair, 1'b0});
          rf_wdata_a_o <= rd_even;
          rf_we_b_o    <= 1'b1;
          rf_waddr_b_o <= ADDR_WIDTH'({rd_pair, 1'b1});
          rf_wdata_b_o <= rd_odd;
        end

        case (state)
          IDLE: begin
            if (pc_commit_i) shadow_pc <= make_pc_entry(pc_i);
            if (recover_req_i) begin
              state       <= HALT;
              busy_o      <= 1'b1;
              core_halt_o <= 1'b1;
              halt_timer  <= '0;
              halt_lost   <= 1'b0;
            end
          end
          HALT: begin
            if (core_halted_i) begin
              state    <= RESTORE;
              pair_idx <= '0;
            end else if (halt_timer == TIMER_LAST) begin
              err_o       <= 1'b1;
              state       <= IDLE;
              busy_o      <= 1'b0;
              core_halt_o <= 1'b0;
            end else begin
              halt_timer <= halt_timer + 1'b1;
            end
          end
          RESTORE: begin
            if (!core_halted_i) halt_lost <= 1'b1;
            if (last_pair) begin
              state         <= PCREC;
              pc_recover_o  <= 1'b1;
              recovery_pc_o <= shadow_pc.data;
            end else begin
              pair_idx <= pair_idx + 1'b1;
            end
          end
          PCREC: begin
            state  <= DONE;
            done_o <= 1'b1;
            err_o  <= halt_lost;
          end
          DONE: begin
            state       <= IDLE;
            busy_o      <= 1'b0;
            core_halt_o <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cv32e40p_recovery_sequencer.sv
// Directed self-checking bench for cv32e40p_recovery_sequencer (default build, 32 registers).
module tb_cv32e40p_recovery_sequencer;

  localparam int unsigned NUM_REGS     = 32;
  localparam int unsigned DATA_WIDTH   = 32;
  localparam int unsigned ADDR_WIDTH   = 6;
  localparam int unsigned HALT_TIMEOUT = 64;

  logic                  clk = 1'b0;
  logic                  rst_i;
  logic                  rf_we_a_i;
  logic [ADDR_WIDTH-1:0] rf_waddr_a_i;
  logic [DATA_WIDTH-1:0] rf_wdata_a_i;
  logic                  rf_we_b_i;
  logic [ADDR_WIDTH-1:0] rf_waddr_b_i;
  logic [DATA_WIDTH-1:0] rf_wdata_b_i;
  logic                  pc_commit_i;
  logic [31:0]           pc_i;
  logic                  recover_req_i;
  logic                  core_halted_i;
  logic                  core_halt_o;
  logic                  rf_recover_o;
  logic                  rf_we_a_o;
  logic [ADDR_WIDTH-1:0] rf_waddr_a_o;
  logic [DATA_WIDTH-1:0] rf_wdata_a_o;
  logic                  rf_we_b_o;
  logic [ADDR_WIDTH-1:0] rf_waddr_b_o;
  logic [DATA_WIDTH-1:0] rf_wdata_b_o;
  logic                  pc_recover_o;
  logic [31:0]           recovery_pc_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  err_o;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] exp_rf [NUM_REGS];

  cv32e40p_recovery_sequencer #(
    .NUM_REGS    (NUM_REGS),
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .HALT_TIMEOUT(HALT_TIMEOUT)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .rf_we_a_i    (rf_we_a_i),
    .rf_waddr_a_i (rf_waddr_a_i),
    .rf_wdata_a_i (rf_wdata_a_i),
    .rf_we_b_i    (rf_we_b_i),
    .rf_waddr_b_i (rf_waddr_b_i),
    .rf_wdata_b_i (rf_wdata_b_i),
    .pc_commit_i  (pc_commit_i),
    .pc_i         (pc_i),
    .recover_req_i(recover_req_i),
    .core_halted_i(core_halted_i),
    .core_halt_o  (core_halt_o),
    .rf_recover_o (rf_recover_o),
    .rf_we_a_o    (rf_we_a_o),
    .rf_waddr_a_o (rf_waddr_a_o),
    .rf_wdata_a_o (rf_wdata_a_o),
    .rf_we_b_o    (rf_we_b_o),
    .rf_waddr_b_o (rf_waddr_b_o),
    .rf_wdata_b_o (rf_wdata_b_o),
    .pc_recover_o (pc_recover_o),
    .recovery_pc_o(recovery_pc_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we_a, input logic [ADDR_WIDTH-1:0] addr_a,
                               input logic [DATA_WIDTH-1:0] data_a, input logic we_b,
                               input logic [ADDR_WIDTH-1:0] addr_b,
                               input logic [DATA_WIDTH-1:0] data_b, input logic commit,
                               input logic [31:0] pc, input logic req, input logic halted);
    rf_we_a_i     = we_a;
    rf_waddr_a_i  = addr_a;
    rf_wdata_a_i  = data_a;
    rf_we_b_i     = we_b;
    rf_waddr_b_i  = addr_b;
    rf_wdata_b_i  = data_b;
    pc_commit_i   = commit;
    pc_i          = pc;
    recover_req_i = req;
    core_halted_i = halted;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkBit({tag, " busy"}, busy_o, 1'b0);
    checkBit({tag, " core_halt"}, core_halt_o, 1'b0);
    checkBit({tag, " rf_recover"}, rf_recover_o, 1'b0);
    checkBit({tag, " we_a"}, rf_we_a_o, 1'b0);
    checkBit({tag, " we_b"}, rf_we_b_o, 1'b0);
    checkOutput({tag, " waddr_a"}, 32'(rf_waddr_a_o), 32'h0);
    checkOutput({tag, " wdata_b"}, rf_wdata_b_o, 32'h0);
    checkBit({tag, " pc_recover"}, pc_recover_o, 1'b0);
    checkOutput({tag, " recovery_pc"}, recovery_pc_o, 32'h0);
    checkBit({tag, " done"}, done_o, 1'b0);
    checkBit({tag, " err"}, err_o, 1'b0);
  endtask

  // Request with core already halted; returns in cycle 2 (RESTORE k=0).
  task automatic startRecovery(input string tag);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    checkBit({tag, " c1 busy"}, busy_o, 1'b1);
    checkBit({tag, " c1 core_halt"}, core_halt_o, 1'b1);
    checkBit({tag, " c1 rf_recover"}, rf_recover_o, 1'b0);
    recover_req_i = 1'b0;
    tick();
  endtask

  // Walks k=0..15 against exp_rf; halted is dropped for drop_from <= k < drop_to.
  // With inject set, checkpoint writes are attempted at k=0 and must be ignored.
  task automatic checkRestore(input string tag, input int drop_from, input int drop_to,
                              input logic inject);
    for (int k = 0; k < int'(NUM_REGS / 2); k++) begin
      core_halted_i = !(k >= drop_from && k < drop_to);
      if (inject && k == 0) begin
        applyStimulus(1'b1, 6'd9, 32'h55, 1'b1, 6'd10, 32'h66, 1'b1, 32'hBAD0, 1'b0, 1'b1);
      end else if (inject && k == 1) begin
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 32'h0, 1'b0, 1'b1);
      end
      checkBit($sformatf("%s k%0d rf_recover", tag, k), rf_recover_o, 1'b1);
      checkBit($sformatf("%s k%0d we_a", tag, k), rf_we_a_o, k != 0);
      checkOutput($sformatf("%s k%0d waddr_a", tag, k), 32'(rf_waddr_a_o), 2 * k);
      checkOutput($sformatf("%s k%0d wdata_a", tag, k), rf_wdata_a_o, exp_rf[2*k]);
      checkBit($sformatf("%s k%0d we_b", tag, k), rf_we_b_o, 1'b1);
      checkOutput($sformatf("%s k%0d waddr_b", tag, k), 32'(rf_waddr_b_o), 2 * k + 1);
      checkOutput($sformatf("%s k%0d wdata_b", tag, k), rf_wdata_b_o, exp_rf[2*k+1]);
      checkBit($sformatf("%s k%0d core_halt", tag, k), core_halt_o, 1'b1);
      checkBit($sformatf("%s k%0d done", tag, k), done_o, 1'b0);
      tick();
    end
    core_halted_i = 1'b1;
  endtask

  initial begin
    rst_i = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < int'(NUM_REGS); i++) exp_rf[i] = 32'h0;
    tick();
    tick();
    $display("[TB] reset state");
    checkIdleOutputs("reset");
    rst_i = 1'b0;
    tick();

    $display("[TB] checkpoint writes and full restore");
    applyStimulus(1'b1, 6'd5, 32'hDEADBEEF, 1'b1, 6'd6, 32'h12345678, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 6'd7, 32'h1, 1'b1, 6'd7, 32'h2, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 6'd0, 32'hFF, 1'b1, 6'd40, 32'hAAAA, 1'b1, 32'h1C000080, 1'b0, 1'b1);
    tick();
    exp_rf[5] = 32'hDEADBEEF;
    exp_rf[6] = 32'h12345678;
    exp_rf[7] = 32'h1;
    checkIdleOutputs("ckpt");
    startRecovery("rec1");
    checkRestore("rec1", -1, -1, 1'b1);
    checkBit("rec1 c18 pc_recover", pc_recover_o, 1'b1);
    checkOutput("rec1 c18 recovery_pc", recovery_pc_o, 32'h1C000080);
    checkBit("rec1 c18 rf_recover", rf_recover_o, 1'b0);
    checkBit("rec1 c18 done", done_o, 1'b0);
    tick();
    checkBit("rec1 c19 done", done_o, 1'b1);
    checkBit("rec1 c19 err", err_o, 1'b0);
    checkBit("rec1 c19 core_halt", core_halt_o, 1'b1);
    checkBit("rec1 c19 pc_recover", pc_recover_o, 1'b0);
    checkOutput("rec1 c19 recovery_pc", recovery_pc_o, 32'h0);
    tick();
    checkIdleOutputs("rec1 c20");

    $display("[TB] halt lost during restore");
    startRecovery("loss");
    checkRestore("loss", 3, 5, 1'b0);
    checkOutput("loss c18 recovery_pc", recovery_pc_o, 32'h1C000080);
    tick();
    checkBit("loss c19 done", done_o, 1'b1);
    checkBit("loss c19 err", err_o, 1'b1);
    tick();
    checkBit("loss c20 err", err_o, 1'b0);
    checkBit("loss c20 busy", busy_o, 1'b0);

    $display("[TB] halt timeout");
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    recover_req_i = 1'b0;
    repeat (63) tick();
    checkBit("tmo c64 err", err_o, 1'b0);
    checkBit("tmo c64 busy", busy_o, 1'b1);
    checkBit("tmo c64 core_halt", core_halt_o, 1'b1);
    tick();
    checkBit("tmo c65 err", err_o, 1'b1);
    checkBit("tmo c65 busy", busy_o, 1'b0);
    checkBit("tmo c65 core_halt", core_halt_o, 1'b0);
    checkBit("tmo c65 done", done_o, 1'b0);
    tick();
    checkBit("tmo c66 err", err_o, 1'b0);

    $display("[TB] reset in the middle of restore");
    startRecovery("rstmid");
    repeat (4) tick();
    checkOutput("rstmid k4 waddr_a", 32'(rf_waddr_a_o), 32'd8);
    checkBit("rstmid k4 rf_recover", rf_recover_o, 1'b1);
    rst_i = 1'b1;
    tick();
    checkIdleOutputs("rstmid");
    rst_i = 1'b0;
    tick();
    checkIdleOutputs("rstmid post");
    for (int i = 0; i < int'(NUM_REGS); i++) exp_rf[i] = 32'h0;
    startRecovery("zero");
    checkRestore("zero", -1, -1, 1'b0);
    checkBit("zero c18 pc_recover", pc_recover_o, 1'b1);
    checkOutput("zero c18 recovery_pc", recovery_pc_o, 32'h0);
    tick();
    checkBit("zero c19 done", done_o, 1'b1);
    checkBit("zero c19 err", err_o, 1'b0);
    tick();
    checkIdleOutputs("zero c20");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
